// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the pipeline register file.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_files_if.sv
// Decode/writeback bus of the register file: two packed read addresses, one write port.
interface reg_files_if
  import regfile_pkg::*;
();

  logic [2*ADDR_W-1:0] rs_rt;
  addr_t               rwd;
  data_t               wb_data;
  data_t               val_rs;
  data_t               val_rt;

  modport master (output rs_rt, rwd, wb_data, input val_rs, val_rt);
  modport slave  (input rs_rt, rwd, wb_data, output val_rs, val_rt);

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: array index, R0 forcing and, with REGFILE_BYPASS_EN,
// a write-through bypass from the writeback bus.
module regfile_rd_port
  import regfile_pkg::*;
(
`ifdef REGFILE_BYPASS_EN
  input  logic  rst_ni,
  input  addr_t rwd_i,
  input  data_t wb_data_i,
`endif
  input  addr_t addr_i,
  input  data_t mem_i [NUM_REGS],
  output data_t data_o
);

  // NOTE: data_o gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    data_o = mem_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    if (rst_ni && (rwd_i != REG_ZERO) && (rwd_i == addr_i)) begin
      data_o = wb_data_i;
    end
`endif
    if (addr_i == REG_ZERO) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/reg_files.sv
// 32 x 32-bit register file: async-cleared storage, one write per CLK, two read ports.
// Optional write-through bypass on the read ports via REGFILE_BYPASS_EN.
module reg_files
  import regfile_pkg::*;
(
  input  logic        CLK,
  input  logic        rst_n,
  reg_files_if.slave  rf
);

  data_t mem_q [NUM_REGS];

  // NOTE: this storage is reset on purpose, since every register must read 0 from reset onward.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (rf.rwd != REG_ZERO) begin
      mem_q[rf.rwd] <= rf.wb_data;
    end
  end

  regfile_rd_port u_rd_rs (
`ifdef REGFILE_BYPASS_EN
    .rst_ni    (rst_n),
    .rwd_i     (rf.rwd),
    .wb_data_i (rf.wb_data),
`endif
    .addr_i    (rf.rs_rt[2*ADDR_W-1:ADDR_W]),
    .mem_i     (mem_q),
    .data_o    (rf.val_rs)
  );

  regfile_rd_port u_rd_rt (
`ifdef REGFILE_BYPASS_EN
    .rst_ni    (rst_n),
    .rwd_i     (rf.rwd),
    .wb_data_i (rf.wb_data),
`endif
    .addr_i    (rf.rs_rt[ADDR_W-1:0]),
    .mem_i     (mem_q),
    .data_o    (rf.val_rt)
  );

endmodule

// File: tb/tb_reg_files.sv
// Self-checking bench for reg_files: directed table, bypass/reset sequences, full sweep
// and randomized traffic against an array model; follows REGFILE_BYPASS_EN if defined.
module tb_reg_files;

  logic CLK = 1'b0;
  logic rst_n;

  reg_files_if rf_if ();

  reg_files u_dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .rf    (rf_if.slave)
  );

  always #5 CLK = ~CLK;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];

  typedef struct {
    string       name;
    logic [4:0]  rwd;
    logic [31:0] wb;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference read: R0 is zero, reset forces zero, bypass returns the bus value.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0 || !rst_n) return 32'd0;
    if (BYPASS && rf_if.rwd != 5'd0 && a == rf_if.rwd) return rf_if.wb_data;
    return model[a];
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (rst_n && rf_if.rwd != 5'd0) model[rf_if.rwd] = rf_if.wb_data;
    #1;
  endtask

  task automatic set_rd(input logic [4:0] rs, input logic [4:0] rt);
    rf_if.rs_rt = {rs, rt};
  endtask

  task automatic check_model(input string tag);
    #1;
    check({tag, "_rs"}, rf_if.val_rs, exp_read(rf_if.rs_rt[9:5]));
    check({tag, "_rt"}, rf_if.val_rt, exp_read(rf_if.rs_rt[4:0]));
  endtask

  initial begin
    vecs[0] = '{"wr_r5",        5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{"r0_nowrite",   5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[2] = '{"wr_r7",        5'd7,  32'h0BADF00D, 5'd7,  5'd5,  32'h0BADF00D, 32'hDEADBEEF};
    vecs[3] = '{"wr_r31",       5'd31, 32'h00000001, 5'd31, 5'd0,  32'h00000001, 32'h0};
    vecs[4] = '{"overwrite_r5", 5'd5,  32'h13579BDF, 5'd5,  5'd31, 32'h13579BDF, 32'h00000001};
    vecs[5] = '{"others_kept",  5'd0,  32'hFFFFFFFF, 5'd7,  5'd5,  32'h0BADF00D, 32'h13579BDF};

    foreach (model[i]) model[i] = 32'd0;

    // Reset state, with live-looking traffic on the bus.
    rst_n         = 1'b0;
    rf_if.rwd     = 5'd3;
    rf_if.wb_data = 32'h11112222;
    set_rd(5'd3, 5'd12);
    tick();
    check("reset_rs", rf_if.val_rs, 32'd0);
    check("reset_rt", rf_if.val_rt, 32'd0);
    rf_if.rwd = 5'd0;
    @(negedge CLK);
    rst_n = 1'b1;
    #1;
    check("post_reset_rs", rf_if.val_rs, 32'd0);
    check("post_reset_rt", rf_if.val_rt, 32'd0);

    // Directed table: write on one edge, read back after it with the write bus idle.
    for (int v = 0; v < 6; v++) begin
      rf_if.rwd     = vecs[v].rwd;
      rf_if.wb_data = vecs[v].wb;
      tick();
      rf_if.rwd     = 5'd0;
      rf_if.wb_data = $urandom | 32'h1;
      set_rd(vecs[v].rs, vecs[v].rt);
      #1;
      check({vecs[v].name, "_rs"}, rf_if.val_rs, vecs[v].exp_rs);
      check({vecs[v].name, "_rt"}, rf_if.val_rt, vecs[v].exp_rt);
    end

    // Same-cycle read of the register being written.
    rf_if.rwd     = 5'd7;
    rf_if.wb_data = 32'h12345678;
    set_rd(5'd7, 5'd3);
    #1;
    check("bypass_pre_rs", rf_if.val_rs, BYPASS ? 32'h12345678 : 32'h0BADF00D);
    check("bypass_pre_rt", rf_if.val_rt, 32'd0);
    tick();
    rf_if.rwd = 5'd0;
    #1;
    check("bypass_post_rs", rf_if.val_rs, 32'h12345678);

    // Bypass never applies to R0, nor does a write to it.
    rf_if.rwd     = 5'd0;
    rf_if.wb_data = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0);
    #1;
    check("r0_bus_rs", rf_if.val_rs, 32'd0);
    check("r0_bus_rt", rf_if.val_rt, 32'd0);

    // Full sweep of r1..r31 and every read pair.
    for (int i = 1; i < 32; i++) begin
      rf_if.rwd     = 5'(i);
      rf_if.wb_data = 32'hA5000000 | 32'(i);
      tick();
    end
    rf_if.rwd = 5'd0;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        set_rd(5'(a), 5'(b));
        #1;
        check("sweep_rs", rf_if.val_rs, (a == 0) ? 32'd0 : (32'hA5000000 | 32'(a)));
        check("sweep_rt", rf_if.val_rt, (b == 0) ? 32'd0 : (32'hA5000000 | 32'(b)));
      end
    end

    // Randomized traffic, read addresses often aimed at the write target.
    for (int n = 0; n < 400; n++) begin
      rf_if.rwd     = 5'($urandom_range(0, 31));
      rf_if.wb_data = $urandom;
      set_rd(($urandom_range(0, 3) == 0) ? rf_if.rwd : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 3) == 0) ? rf_if.rwd : 5'($urandom_range(0, 31)));
      check_model("rand");
      tick();
    end

    // Asynchronous reset between edges, after writes.
    rf_if.rwd     = 5'd9;
    rf_if.wb_data = 32'h00000099;
    tick();
    rf_if.rwd = 5'd0;
    set_rd(5'd9, 5'd9);
    #1;
    check("pre_async_rs", rf_if.val_rs, 32'h00000099);
    rst_n = 1'b0;
    foreach (model[i]) model[i] = 32'd0;
    #1;
    check("async_rst_rs", rf_if.val_rs, 32'd0);
    check("async_rst_rt", rf_if.val_rt, 32'd0);

    // Writes are ignored while held in reset, and the bypass is gated too.
    rf_if.rwd     = 5'd9;
    rf_if.wb_data = 32'h55555555;
    #1;
    check("rst_bypass_rs", rf_if.val_rs, 32'd0);
    tick();
    check("rst_write_rs", rf_if.val_rs, 32'd0);
    rf_if.rwd = 5'd0;
    @(negedge CLK);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      check("cleared_rs", rf_if.val_rs, 32'd0);
      check("cleared_rt", rf_if.val_rt, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
